// File: rtl/debounce_pkg.sv
// Shared types and constants for the switch debouncer.
//   db_state_t : stable-count FSM state encoding
//   PRESS_W    : width of the wrapping press counter
package debounce_pkg;

    localparam int unsigned PRESS_W = 8;

    typedef enum logic [1:0] {
        IDLE_LOW  = 2'd0,
        WAIT_HIGH = 2'd1,
        IDLE_HIGH = 2'd2,
        WAIT_LOW  = 2'd3
    } db_state_t;

endpackage : debounce_pkg

// File: rtl/sync_chain.sv
// Multi-flop synchronizer for a single asynchronous input.
//   CLK50M : destination clock
//   rst_n  : asynchronous active-low reset, clears every stage to 0
//   d      : asynchronous input
//   q      : synchronized output (last stage)
// STAGES must be >= 2.
module sync_chain #(
    parameter int unsigned STAGES = 2
) (
    input  logic CLK50M,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] r_sync;

    // Shift chain: new sample enters at bit 0, leaves at the top bit.
    always_ff @(posedge CLK50M or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], d};
        end
    end

    assign q = r_sync[STAGES-1];

endmodule : sync_chain

// File: rtl/switch_debouncer_fsm.sv
// Debounces one raw mechanical switch into a clean level with edge pulses.
//   CLK50M      : 50 MHz board clock
//   rst_n       : asynchronous active-low reset
//   A_noisy     : raw, bouncing switch input (asynchronous)
//   A           : debounced level (registered)
//   A_rise      : one-cycle pulse on the edge A goes 0->1
//   A_fall      : one-cycle pulse on the edge A goes 1->0
//   press_count : wrapping count of A_rise events
// STABLE_CYCLES >= 2, SYNC_STAGES >= 2; CNT_W is derived and not overridden.
module switch_debouncer_fsm
    import debounce_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 500000,
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned CNT_W         = $clog2(STABLE_CYCLES)
) (
    input  logic               CLK50M,
    input  logic               rst_n,
    input  logic               A_noisy,
    output logic               A,
    output logic               A_rise,
    output logic               A_fall,
    output logic [PRESS_W-1:0] press_count
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    logic             w_s;
    db_state_t        r_state;
    db_state_t        w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_a_nxt;
    logic             w_rise_nxt;
    logic             w_fall_nxt;

    // Bring the raw switch into the clock domain.
    sync_chain #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .CLK50M (CLK50M),
        .rst_n  (rst_n),
        .d      (A_noisy),
        .q      (w_s)
    );

    // State and stability counter registers.
    always_ff @(posedge CLK50M or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE_LOW;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state: a new level must persist STABLE_CYCLES samples; any
    // sample back at the old level aborts to the matching idle state.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        unique case (r_state)
            IDLE_LOW: begin
                if (w_s) begin
                    w_state_nxt = WAIT_HIGH;
                    w_cnt_nxt   = CNT_ONE;
                end
            end
            WAIT_HIGH: begin
                if (!w_s) begin
                    w_state_nxt = IDLE_LOW;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == CNT_MAX) begin
                    w_state_nxt = IDLE_HIGH;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt + CNT_ONE;
                end
            end
            IDLE_HIGH: begin
                if (!w_s) begin
                    w_state_nxt = WAIT_LOW;
                    w_cnt_nxt   = CNT_ONE;
                end
            end
            WAIT_LOW: begin
                if (w_s) begin
                    w_state_nxt = IDLE_HIGH;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == CNT_MAX) begin
                    w_state_nxt = IDLE_LOW;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt + CNT_ONE;
                end
            end
            default: begin
                w_state_nxt = IDLE_LOW;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // A follows the current state one edge later; the edge pulses are the
    // difference between the new and old value of A, so they land on the
    // same edge A changes and can never both be high.
    always_comb begin
        w_a_nxt    = (r_state == IDLE_HIGH) || (r_state == WAIT_LOW);
        w_rise_nxt = w_a_nxt && !A;
        w_fall_nxt = !w_a_nxt && A;
    end

    // Registered outputs.
    always_ff @(posedge CLK50M or negedge rst_n) begin
        if (!rst_n) begin
            A           <= 1'b0;
            A_rise      <= 1'b0;
            A_fall      <= 1'b0;
            press_count <= '0;
        end else begin
            A      <= w_a_nxt;
            A_rise <= w_rise_nxt;
            A_fall <= w_fall_nxt;
            if (w_rise_nxt) begin
                press_count <= press_count + PRESS_W'(1);
            end
        end
    end

endmodule : switch_debouncer_fsm

// File: tb/tb_switch_debouncer_fsm.sv
// Directed self-checking bench for switch_debouncer_fsm (STABLE_CYCLES=4, SYNC_STAGES=2).
module tb_switch_debouncer_fsm;

    logic       CLK50M;
    logic       rst_n;
    logic       A_noisy;
    logic       A;
    logic       A_rise;
    logic       A_fall;
    logic [7:0] press_count;

    int n_pass;
    int n_total;

    switch_debouncer_fsm #(
        .STABLE_CYCLES (4),
        .SYNC_STAGES   (2)
    ) dut (
        .CLK50M      (CLK50M),
        .rst_n       (rst_n),
        .A_noisy     (A_noisy),
        .A           (A),
        .A_rise      (A_rise),
        .A_fall      (A_fall),
        .press_count (press_count)
    );

    initial CLK50M = 1'b0;
    always #10 CLK50M = ~CLK50M;

    // Advance one clock; leave time 1 unit after the active edge.
    task automatic step;
        @(posedge CLK50M);
        #1;
    endtask

    // Pulse reset for two edges with A_noisy held at the given level.
    task automatic do_reset(input logic lvl);
        rst_n   = 1'b0;
        A_noisy = lvl;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        logic [10:0] got;
        rst_n = 1'b0;
        for (int i = 0; i < 8; i++) begin
            A_noisy = (i % 2 == 0);
            step();
            got = {A, A_rise, A_fall, press_count};
            n_total++;
            if (got !== 11'd0) $display("FAIL reset cyc%0d got=%b exp=%b", i, got, 11'd0);
            else n_pass++;
        end
        A_noisy = 1'b0;
        rst_n   = 1'b1;
        for (int i = 0; i < 4; i++) step();
        got = {A, A_rise, A_fall, press_count};
        n_total++;
        if (got !== 11'd0) $display("FAIL reset_idle got=%b exp=%b", got, 11'd0);
        else n_pass++;
    endtask

    // Clean press, then release from the resulting stable high.
    task automatic test_press_release;
        logic [10:0] got, exp;
        do_reset(1'b0);
        step();
        A_noisy = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            got = {A, A_rise, A_fall, press_count};
            exp = {(k >= 6), (k == 6), 1'b0, (k >= 6) ? 8'd1 : 8'd0};
            n_total++;
            if (got !== exp) $display("FAIL press edge%0d got=%b exp=%b", k, got, exp);
            else n_pass++;
        end
        A_noisy = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            got = {A, A_rise, A_fall, press_count};
            exp = {(k < 6), 1'b0, (k == 6), 8'd1};
            n_total++;
            if (got !== exp) $display("FAIL release edge%0d got=%b exp=%b", k, got, exp);
            else n_pass++;
        end
    endtask

    // High 3, low 1, high 1, low 1, then held high from cycle 6.
    task automatic test_bounce;
        logic [10:0] got, exp;
        logic [5:0]  pat;
        pat = 6'b010111;
        do_reset(1'b0);
        step();
        for (int k = 0; k < 18; k++) begin
            A_noisy = (k < 6) ? pat[k] : 1'b1;
            step();
            got = {A, A_rise, A_fall, press_count};
            exp = {(k >= 12), (k == 12), 1'b0, (k >= 12) ? 8'd1 : 8'd0};
            n_total++;
            if (got !== exp) $display("FAIL bounce edge%0d got=%b exp=%b", k, got, exp);
            else n_pass++;
        end
    endtask

    task automatic test_wrap;
        int n_rise;
        n_rise = 0;
        do_reset(1'b0);
        step();
        for (int p = 1; p <= 256; p++) begin
            A_noisy = 1'b1;
            for (int k = 0; k < 8; k++) begin
                step();
                if (A_rise) n_rise++;
            end
            A_noisy = 1'b0;
            for (int k = 0; k < 8; k++) begin
                step();
                if (A_rise) n_rise++;
            end
            if (p == 255 || p == 256 || p == 1 || p == 128) begin
                n_total++;
                if (press_count !== 8'(p)) $display("FAIL wrap_count press%0d got=%0d exp=%0d", p, press_count, 8'(p));
                else n_pass++;
            end
        end
        n_total++;
        if (n_rise !== 256) $display("FAIL wrap_rises got=%0d exp=256", n_rise);
        else n_pass++;
    endtask

    task automatic test_mid_reset;
        logic [10:0] got;
        do_reset(1'b0);
        step();
        A_noisy = 1'b1;
        for (int k = 0; k < 4; k++) step();
        n_total++;
        if (dut.r_state !== debounce_pkg::WAIT_HIGH || dut.r_cnt !== 2'd2)
            $display("FAIL mid_reset_setup got state=%0d cnt=%0d exp state=1 cnt=2", dut.r_state, dut.r_cnt);
        else n_pass++;
        rst_n   = 1'b0;
        A_noisy = 1'b0;
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            step();
            got = {A, A_rise, A_fall, press_count};
            n_total++;
            if (got !== 11'd0) $display("FAIL mid_reset edge%0d got=%b exp=%b", k, got, 11'd0);
            else n_pass++;
        end
    endtask

    // Input already high when reset releases: debounced like any press.
    task automatic test_high_through_reset;
        logic [10:0] got, exp;
        do_reset(1'b1);
        for (int k = 0; k < 10; k++) begin
            step();
            got = {A, A_rise, A_fall, press_count};
            exp = {(k >= 6), (k == 6), 1'b0, (k >= 6) ? 8'd1 : 8'd0};
            n_total++;
            if (got !== exp) $display("FAIL high_thru_reset edge%0d got=%b exp=%b", k, got, exp);
            else n_pass++;
        end
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        rst_n   = 1'b0;
        A_noisy = 1'b0;
        #5;
        test_reset();
        test_press_release();
        test_bounce();
        test_wrap();
        test_mid_reset();
        test_high_through_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_switch_debouncer_fsm
